hazard_ctrl_p: RTL

- Parametrised hazard controller for the 5-stage MIPS pipeline.
- Replaces fixed per-opcode stall tables with a Tuse/Tnew scoreboard. Decode supplies operand-use times and the result-ready time per instruction.
- Adds a mult/div busy tracker (HI/LO interlock) and a configurable forwarding-source encoding.
- Sits beside the datapath. Drives the F/D hold, the E bubble and every bypass-mux select.

---
 rtl/hazard_pkg.sv | 60 ++++++
 rtl/hazard_ctrl_p_md.sv | 34 +++
 rtl/hazard_ctrl_p.sv | 105 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the MIPS hazard controller: forwarding-source codes,
// default field widths, the shadow-stage record and small helper functions.
package hazard_pkg;

  // Default field widths; the shadow-stage record is built from these.
  localparam int unsigned HZ_REG_AW = 5;
  localparam int unsigned HZ_T_W    = 2;

  // Bypass-mux source encoding shared with the datapath.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  // Per-stage shadow of the instruction travelling down the datapath.
  typedef struct packed {
    logic [HZ_REG_AW-1:0] a3;
    logic [HZ_T_W-1:0]    tnew;
    logic [HZ_REG_AW-1:0] rs;
    logic [HZ_REG_AW-1:0] rt;
  } stage_t;

  // Move a record one stage down; tnew counts down and sticks at zero.
  function automatic stage_t stage_advance(input stage_t s);
    stage_t n;
    n = s;
    if (s.tnew != '0) n.tnew = s.tnew - HZ_T_W'(1);
    return n;
  endfunction

  // True when an operand read at tuse cannot yet be satisfied by stage s.
  function automatic logic hazard_hit(input logic [HZ_REG_AW-1:0] r,
                                      input logic [HZ_T_W-1:0]    tuse,
                                      input logic                 use_op,
                                      input stage_t               s);
    return use_op && (r != '0) && (s.a3 == r) && (s.tnew > tuse);
  endfunction

  // Nearest-producer bypass select. The nearest stage writing r decides:
  // its value if ready, otherwise the register file (stall covers it).
  function automatic logic [1:0] fwd_pick(input logic [HZ_REG_AW-1:0] r,
                                          input stage_t e,
                                          input stage_t m,
                                          input stage_t w,
                                          input logic   en_e,
                                          input logic   en_m);
    logic [1:0] sel;
    sel = FWD_RF;
    if (r == '0)
      sel = FWD_RF;
    else if (en_e && (e.a3 == r))
      sel = (e.tnew == '0) ? FWD_E : FWD_RF;
    else if (en_m && (m.a3 == r))
      sel = (m.tnew == '0) ? FWD_M : FWD_RF;
    else if (w.a3 == r)
      sel = (w.tnew == '0) ? FWD_W : FWD_RF;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_p_md.sv
// md_busy_tracker: occupancy counter for the mult/div unit.
//   clk, reset (sync, active-low) | start: MD instruction in E this cycle
//   div: that instruction is a divide | busy: unit occupied (counter != 0)
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  // Load at the end of the E cycle so busy covers exactly the occupancy window.
  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else if (start)
      cnt_q <= div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    else if (cnt_q != '0)
      cnt_q <= cnt_q - CNT_W'(1);
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: Tuse/Tnew hazard controller for the 5-stage MIPS pipeline.
//   Inputs : D-stage operand regs, use flags and use times, destination and
//            result-ready time, MD start/divide/use flags; clk, reset (sync, low).
//   Outputs: stall (hold F/D, bubble E), bypass selects for D, E and M
//            consumers, per-stage destinations a3_e/m/w, md_busy.
// Record widths come from hazard_pkg; override REG_AW/T_W only together
// with the package defaults.
module hazard_ctrl_p
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = HZ_REG_AW,
  parameter int unsigned T_W      = HZ_T_W,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic [T_W-1:0]    tnew_d,
  input  logic              md_start_d,
  input  logic              md_div_d,
  input  logic              md_use_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic [1:0]        fwd_rt_m,
  output logic [REG_AW-1:0] a3_e,
  output logic [REG_AW-1:0] a3_m,
  output logic [REG_AW-1:0] a3_w,
  output logic              md_busy
);

  stage_t e_q, m_q, w_q;
  stage_t d_rec;
  logic   md_start_e_q, md_div_e_q;
  logic   rs_conflict, rt_conflict, md_lock;
  logic   unused_stage_bits;

  assign d_rec = '{a3:   HZ_REG_AW'(a3_d),
                   tnew: HZ_T_W'(tnew_d),
                   rs:   HZ_REG_AW'(rs_d),
                   rt:   HZ_REG_AW'(rt_d)};

  // Shadow pipeline; a stall turns the E slot into a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q          <= '0;
      m_q          <= '0;
      w_q          <= '0;
      md_start_e_q <= 1'b0;
      md_div_e_q   <= 1'b0;
    end else begin
      e_q          <= stall ? '0 : d_rec;
      m_q          <= stage_advance(e_q);
      w_q          <= stage_advance(m_q);
      md_start_e_q <= !stall && md_start_d;
      md_div_e_q   <= !stall && md_start_d && md_div_d;
    end
  end

  md_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy (
    .clk   (clk),
    .reset (reset),
    .start (md_start_e_q),
    .div   (md_div_e_q),
    .busy  (md_busy)
  );

  // Operand conflicts against the two stages that can still be producing.
  assign rs_conflict = hazard_hit(HZ_REG_AW'(rs_d), HZ_T_W'(tuse_rs_d), use_rs_d, e_q) ||
                       hazard_hit(HZ_REG_AW'(rs_d), HZ_T_W'(tuse_rs_d), use_rs_d, m_q);
  assign rt_conflict = hazard_hit(HZ_REG_AW'(rt_d), HZ_T_W'(tuse_rt_d), use_rt_d, e_q) ||
                       hazard_hit(HZ_REG_AW'(rt_d), HZ_T_W'(tuse_rt_d), use_rt_d, m_q);

  // HI/LO interlock: an MD op still in E has not loaded the counter yet.
  assign md_lock = (md_start_d || md_use_d) && (md_busy || md_start_e_q);

  assign stall = rs_conflict || rt_conflict || md_lock;

  // Bypass selects; E consumers skip stage E, the store path only sees W.
  assign fwd_rs_d = fwd_pick(HZ_REG_AW'(rs_d), e_q, m_q, w_q, 1'b1, 1'b1);
  assign fwd_rt_d = fwd_pick(HZ_REG_AW'(rt_d), e_q, m_q, w_q, 1'b1, 1'b1);
  assign fwd_rs_e = fwd_pick(e_q.rs, '0, m_q, w_q, 1'b0, 1'b1);
  assign fwd_rt_e = fwd_pick(e_q.rt, '0, m_q, w_q, 1'b0, 1'b1);
  assign fwd_rt_m = fwd_pick(m_q.rt, '0, '0, w_q, 1'b0, 1'b0);

  assign a3_e = REG_AW'(e_q.a3);
  assign a3_m = REG_AW'(m_q.a3);
  assign a3_w = REG_AW'(w_q.a3);

  // Source fields that no later consumer reads.
  assign unused_stage_bits = ^{m_q.rs, w_q.rs, w_q.rt};

endmodule
